qpsk_frame_ctrl: RTL



---
 rtl/qpsk_pkg.sv | 16 +
 rtl/qpsk_frame_csum.sv | 23 ++
 rtl/qpsk_frame_ctrl.sv | 154 +++++++++++++++
 3 files changed

// File: rtl/qpsk_pkg.sv
// rtl/qpsk_pkg.sv - shared state encoding and byte constants for the QPSK framing controller
package qpsk_pkg;
  localparam int unsigned BYTE_W = 8;
  localparam logic [BYTE_W-1:0] DEF_SYNC_BYTE = 8'h7E;
  localparam logic [BYTE_W-1:0] DEF_PAD_BYTE  = 8'h00;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_HDR,
    ST_FETCH,
    ST_WAIT,
    ST_SEND,
    ST_PAD,
    ST_CSUM
  } frame_state_e;
endpackage

// File: rtl/qpsk_frame_csum.sv
// rtl/qpsk_frame_csum.sv - XOR byte accumulator with synchronous clear and enable
module qpsk_frame_csum
  import qpsk_pkg::*;
(
  input  logic              i_clk,
  input  logic              i_reset,
  input  logic              i_clear,
  input  logic              i_en,
  input  logic [BYTE_W-1:0] i_data,
  output logic [BYTE_W-1:0] o_csum
);
  logic [BYTE_W-1:0] r_csum;

  always_ff @(posedge i_clk) begin
    if (i_reset || i_clear) begin
      r_csum <= '0;
    end else if (i_en) begin
      r_csum <= r_csum ^ i_data;
    end
  end

  assign o_csum = r_csum;
endmodule

// File: rtl/qpsk_frame_ctrl.sv
// rtl/qpsk_frame_ctrl.sv - drains demapped bytes from a FIFO into sync/payload/checksum frames
module qpsk_frame_ctrl
  import qpsk_pkg::*;
#(
  parameter int unsigned       FRAME_LEN = 4,
  parameter logic [BYTE_W-1:0] SYNC_BYTE = DEF_SYNC_BYTE,
  parameter logic [BYTE_W-1:0] PAD_BYTE  = DEF_PAD_BYTE,
  parameter int unsigned       TIMEOUT   = 8
) (
  input  logic              i_clk,
  input  logic              i_reset,
  input  logic              i_empty,
  input  logic [BYTE_W-1:0] i_fifo_data,
  output logic              o_read_en,
  output logic [BYTE_W-1:0] o_out_data,
  output logic              o_out_valid,
  input  logic              i_out_ready,
  output logic              o_out_sof,
  output logic              o_out_eof,
  output logic              o_frame_padded,
  output logic [15:0]       o_frame_cnt
);
  localparam logic [7:0] LAST_IDX = 8'(FRAME_LEN - 1);
  localparam logic [7:0] TO_LAST  = 8'(TIMEOUT - 1);

  frame_state_e      r_state, w_state;
  logic [BYTE_W-1:0] r_data, w_data;
  logic              r_valid, w_valid;
  logic              r_sof, w_sof;
  logic              r_eof, w_eof;
  logic              r_padded, w_padded;
  logic [15:0]       r_frame_cnt, w_frame_cnt;
  logic [7:0]        r_byte_cnt, w_byte_cnt;
  logic [7:0]        r_idle_cnt, w_idle_cnt;
  logic              w_read_en, w_accept, w_csum_clr, w_csum_en;
  logic [BYTE_W-1:0] w_csum, w_csum_next;

  qpsk_frame_csum u_csum (
    .i_clk   (i_clk),
    .i_reset (i_reset),
    .i_clear (w_csum_clr),
    .i_en    (w_csum_en),
    .i_data  (r_data),
    .o_csum  (w_csum)
  );

  // The checksum byte must include the payload byte accepted in the same cycle.
  assign w_csum_next = w_csum ^ r_data;
  assign w_accept    = r_valid && i_out_ready;

  always_comb begin
    w_state     = r_state;
    w_data      = r_data;
    w_valid     = r_valid;
    w_sof       = r_sof;
    w_eof       = r_eof;
    w_padded    = r_padded;
    w_frame_cnt = r_frame_cnt;
    w_byte_cnt  = r_byte_cnt;
    w_idle_cnt  = r_idle_cnt;
    w_read_en   = 1'b0;
    w_csum_clr  = 1'b0;
    w_csum_en   = 1'b0;
    case (r_state)
      ST_IDLE: if (!i_empty) begin
        w_state = ST_HDR;
        w_valid = 1'b1;
        w_data  = SYNC_BYTE;
        w_sof   = 1'b1;
      end
      ST_HDR: if (w_accept) begin
        w_state    = ST_FETCH;
        w_valid    = 1'b0;
        w_sof      = 1'b0;
        w_byte_cnt = '0;
        w_idle_cnt = '0;
        w_padded   = 1'b0;
        w_csum_clr = 1'b1;
      end
      ST_FETCH: begin
        if (!i_empty) begin
          w_read_en  = 1'b1;
          w_idle_cnt = '0;
          w_state    = ST_WAIT;
        end else if (r_idle_cnt == TO_LAST) begin
          w_state    = ST_PAD;
          w_padded   = 1'b1;
          w_valid    = 1'b1;
          w_data     = PAD_BYTE;
          w_idle_cnt = '0;
        end else begin
          w_idle_cnt = r_idle_cnt + 8'd1;
        end
      end
      ST_WAIT: begin
        w_data  = i_fifo_data;
        w_valid = 1'b1;
        w_state = ST_SEND;
      end
      ST_SEND, ST_PAD: if (w_accept) begin
        w_csum_en  = 1'b1;
        w_byte_cnt = r_byte_cnt + 8'd1;
        if (r_byte_cnt == LAST_IDX) begin
          w_state = ST_CSUM;
          w_data  = w_csum_next;
          w_eof   = 1'b1;
        end else if (r_state == ST_SEND) begin
          w_state = ST_FETCH;
          w_valid = 1'b0;
        end
      end
      ST_CSUM: if (w_accept) begin
        w_frame_cnt = r_frame_cnt + 16'd1;
        w_valid     = 1'b0;
        w_eof       = 1'b0;
        w_state     = ST_IDLE;
      end
      default: w_state = ST_IDLE;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_state     <= ST_IDLE;
      r_data      <= '0;
      r_valid     <= 1'b0;
      r_sof       <= 1'b0;
      r_eof       <= 1'b0;
      r_padded    <= 1'b0;
      r_frame_cnt <= '0;
      r_byte_cnt  <= '0;
      r_idle_cnt  <= '0;
    end else begin
      r_state     <= w_state;
      r_data      <= w_data;
      r_valid     <= w_valid;
      r_sof       <= w_sof;
      r_eof       <= w_eof;
      r_padded    <= w_padded;
      r_frame_cnt <= w_frame_cnt;
      r_byte_cnt  <= w_byte_cnt;
      r_idle_cnt  <= w_idle_cnt;
    end
  end

  // Read strobe is decoded from FETCH and the live empty flag so it can never fire on an empty FIFO.
  assign o_read_en      = w_read_en && !i_reset;
  assign o_out_data     = r_data;
  assign o_out_valid    = r_valid;
  assign o_out_sof      = r_sof;
  assign o_out_eof      = r_eof;
  assign o_frame_padded = r_padded;
  assign o_frame_cnt    = r_frame_cnt;
endmodule
